// File: rtl/mult_unit.sv
// Sequential signed multiplier with HI/LO result registers.
// Shift-add on operand magnitudes over WIDTH cycles; the sign is applied in a final fix-up cycle.
module mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mfhi_sel,
  input  logic             mflo_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [CntW-1:0]      count_q;
  logic                 sign_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   result;
  logic                 accept;

  // Magnitudes are unsigned WIDTH-bit, so the most negative operand maps to 2**(WIDTH-1).
  always_comb begin
    abs_a  = a[WIDTH-1] ? -a : a;
    abs_b  = b[WIDTH-1] ? -b : b;
    result = sign_q ? -prod_q : prod_q;
    accept = start_mult & ~busy_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy lingers one idle cycle after FIX, so a held start is taken the cycle after.
          busy_q <= 1'b0;
          if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            prod_q   <= '0;
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            count_q  <= CntW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          count_q  <= count_q - CntW'(1);
          if (count_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          {hi_q, lo_q} <= result;
          done_q       <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    if (mfhi_sel)      rd_data = hi_q;
    else if (mflo_sel) rd_data = lo_q;
    else               rd_data = '0;
  end

  assign stall = busy_q & (start_mult | mfhi_sel | mflo_sel);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, randomized products vs a 64-bit
// arithmetic model, plus stall/hold, same-cycle read, and mid-run reset sequences.
module tb_mult_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_mult;
  logic             mfhi_sel;
  logic             mflo_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .mfhi_sel  (mfhi_sel),
    .mflo_sel  (mflo_sel),
    .a         (a),
    .b         (b),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural HI/LO as the bench expects them to be right now.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    return sx * sy;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from idle and check latency, busy length, HI/LO hold and result.
  task automatic do_mult(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [31:0] eh, input logic [31:0] el);
    int busy_cnt = 0;
    int done_at  = -1;
    int done_cnt = 0;
    bit hold_ok  = 1'b1;
    a = ta;
    b = tb;
    start_mult = 1'b1;
    step();
    start_mult = 1'b0;
    for (int k = 0; k < int'(WIDTH) + 4; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end else if (done_at < 0 && (hi !== m_hi || lo !== m_lo)) begin
        hold_ok = 1'b0;
      end
      if (k < int'(WIDTH) + 3) step();
    end
    check({tag, " done_edge"}, 64'(done_at), 64'(WIDTH + 1));
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(WIDTH + 2));
    check({tag, " hold"}, 64'(hold_ok), 64'd1);
    check({tag, " hilo"}, {hi, lo}, {eh, el});
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vecs[7];

  initial begin
    logic [63:0] p;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] a2;
    logic [31:0] b2;
    int cnt;
    bit stall_ok;
    bit hold_ok;
    bit seen;

    vecs[0] = '{32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    start_mult = 1'b0;
    mfhi_sel = 1'b0;
    mflo_sel = 1'b0;
    a = '0;
    b = '0;
    m_hi = '0;
    m_lo = '0;
    #12;
    check("reset_state", {hi, lo, busy, done, stall, rd_data},
          {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    reset = 1'b0;
    step();

    foreach (vecs[i]) do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // HI/LO now 0x3FFFFFFF / 0x00000001 from a fresh product.
    do_mult("mux_setup", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    mfhi_sel = 1'b1; mflo_sel = 1'b1; #1;
    check("mux_both", {rd_data, stall}, {m_hi, 1'b0});
    mfhi_sel = 1'b0; #1;
    check("mux_lo", {rd_data, stall}, {m_lo, 1'b0});
    mfhi_sel = 1'b1; mflo_sel = 1'b0; #1;
    check("mux_hi", rd_data, m_hi);
    mfhi_sel = 1'b0; #1;
    check("mux_none", rd_data, 32'h0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'hFFFF_FFFF;
      p = model(ra, rb);
      do_mult($sformatf("rand%0d", i), ra, rb, p[63:32], p[31:0]);
    end

    // Same-cycle start + MFHI in idle, then held start + MFLO stalled across the whole run.
    a = 32'h0001_0003;
    b = 32'hFFFF_FFF9;
    start_mult = 1'b1;
    mfhi_sel = 1'b1;
    #1;
    check("same_cycle_read", {rd_data, stall}, {m_hi, 1'b0});
    step();
    p  = model(32'h0001_0003, 32'hFFFF_FFF9);
    a2 = 32'h0000_1234;
    b2 = 32'h8765_4321;
    a = a2;
    b = b2;
    mfhi_sel = 1'b0;
    mflo_sel = 1'b1;
    cnt = 0;
    stall_ok = 1'b1;
    hold_ok = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      cnt++;
      if (!stall) stall_ok = 1'b0;
      if (done) seen = 1'b1;
      else if (!seen && (hi !== m_hi || lo !== m_lo)) hold_ok = 1'b0;
      step();
    end
    check("held_busy_cycles", 64'(cnt), 64'(WIDTH + 2));
    check("held_stall", 64'(stall_ok), 64'd1);
    check("held_hold", 64'(hold_ok), 64'd1);
    check("held_first_result", {hi, lo}, p);
    check("held_release", {stall, rd_data}, {1'b0, p[31:0]});
    m_hi = p[63:32];
    m_lo = p[31:0];
    step();
    start_mult = 1'b0;
    mflo_sel = 1'b0;
    check("held_second_started", 64'(busy), 64'd1);
    p = model(a2, b2);
    seen = 1'b0;
    for (int k = 0; k < int'(WIDTH) + 5 && !seen; k++) begin
      if (done) seen = 1'b1;
      else step();
    end
    check("held_second_done", 64'(seen), 64'd1);
    check("held_second_result", {hi, lo}, p);
    m_hi = p[63:32];
    m_lo = p[31:0];
    for (int k = 0; k < 5 && busy; k++) step();

    // Abort a 3x4 at RUN cycle 10 with an asynchronous reset.
    a = 32'd3;
    b = 32'd4;
    start_mult = 1'b1;
    step();
    start_mult = 1'b0;
    for (int k = 0; k < 10; k++) step();
    #2;
    reset = 1'b1;
    #1;
    check("abort_state", {busy, done, hi, lo, stall}, {1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    cnt = 0;
    for (int k = 0; k < int'(WIDTH) + 4; k++) begin
      step();
      if (done || busy) cnt++;
    end
    check("abort_quiet", {64'(cnt), hi, lo}, {64'd0, 32'h0, 32'h0});
    do_mult("after_abort", 32'd3, 32'd4, 32'h0, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start_mult, input, 1: MULT issued by the control unit this cycle.
REQ-005 SHALL have port mfhi_sel, input, 1: MFHI issued this cycle.
REQ-006 SHALL have port mflo_sel, input, 1: MFLO issued this cycle.
REQ-007 SHALL have port a, input, WIDTH: rs operand, signed two's complement.
REQ-008 SHALL have port b, input, WIDTH: rt operand, signed two's complement.
REQ-009 SHALL have port rd_data, output, WIDTH: HI if mfhi_sel, else LO if mflo_sel, else 0.
REQ-010 SHALL have port hi, output, WIDTH: architectural HI register.
REQ-011 SHALL have port lo, output, WIDTH: architectural LO register.
REQ-012 SHALL have port busy, output, 1: a multiply is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when HI/LO are updated.
REQ-014 SHALL have port stall, output, 1: the pipeline must hold the current instruction.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, FIX.
REQ-016 In IDLE with start_mult=1, SHALL latch |a| and |b|, latch sign = a[WIDTH-1]^b[WIDTH-1], clear the 2*WIDTH product accumulator, load count=WIDTH, and go to RUN.
REQ-017 In RUN, each cycle SHALL add the multiplicand to the accumulator when multiplier bit0=1, shift the multiplier right 1, shift the multiplicand left 1, and decrement count.
REQ-018 SHALL go from RUN to FIX on the cycle count reaches 1, i.e. after exactly WIDTH RUN cycles.
REQ-019 In FIX, SHALL write {hi,lo} = sign ? -product : product (2*WIDTH-bit two's complement), pulse done=1 for that cycle's edge output, and return to IDLE.
REQ-020 Latency: start accepted at edge N; busy=1 from edge N through edge N+WIDTH+1; new hi/lo and done=1 visible after edge N+WIDTH+1; busy=0 after edge N+WIDTH+2.
REQ-021 busy SHALL be 1 in RUN and FIX and 0 in IDLE (registered from state).
REQ-022 stall SHALL be combinational: busy & (start_mult | mfhi_sel | mflo_sel).
REQ-023 start_mult while busy SHALL be ignored (operands not relatched) and SHALL raise stall; the held instruction is accepted on the first IDLE cycle.
REQ-024 hi/lo SHALL hold their previous values for the entire operation, changing only in FIX.
REQ-025 rd_data SHALL be combinational; when mfhi_sel and mflo_sel are both 1, HI SHALL take priority.
REQ-026 start_mult and mfhi_sel/mflo_sel in the same IDLE cycle: rd_data SHALL return the old HI/LO and the multiply SHALL start.
REQ-027 Operands 0x80000000 SHALL be handled via the WIDTH-bit unsigned magnitude 0x80000000 (no overflow).
REQ-028 The accumulator SHALL be 2*WIDTH bits with no truncation before FIX.

Reset
REQ-029 On reset=1, asynchronously: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, accumulator=0.
REQ-030 Reset asserted mid-RUN or mid-FIX SHALL abort the operation with no HI/LO update; after release the unit accepts start_mult on the first clk edge.
REQ-031 stall and rd_data SHALL follow from the reset state (stall=0, rd_data=0 when hi=lo=0).

Verification
REQ-032 a=7, b=6, start_mult pulse -> busy for 34 cycles; done pulse; hi=0x00000000, lo=0x0000002A.
REQ-033 a=0xFFFFFFFF (-1), b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 mflo_sel=1 and a second start_mult held during a run -> stall=1 every busy cycle, hi/lo unchanged until FIX, second multiply starts the cycle after busy falls.
REQ-035 reset pulsed at RUN cycle 10 of a=3, b=4 -> busy=0, hi=lo=0, no done pulse; a new 3x4 then gives lo=0x0000000C.
REQ-036 hi=0x12345678, lo=0x9ABCDEF0 with mfhi_sel=mflo_sel=1 -> rd_data=0x12345678; mflo_sel only -> rd_data=0x9ABCDEF0; neither -> rd_data=0.
